// File: rtl/usb_fs_tx_arb.sv
// Round-robin arbiter sharing the USB FS transmit path between NUM_REQ protocol engines.
// Optional ACTIVE-state watchdog enabled by defining USB_TX_ARB_TIMEOUT_EN.
module usb_fs_tx_arb #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_pkt_start,
  input  logic [4*NUM_REQ-1:0]   req_pid,
  input  logic [NUM_REQ-1:0]     req_data_avail,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_data_get,
  output logic [NUM_REQ-1:0]     req_pkt_end,
  output logic [NUM_REQ-1:0]     req_busy,
  output logic                   tx_pkt_start,
  output logic [3:0]             tx_pid,
  output logic                   tx_data_avail,
  output logic [7:0]             tx_data,
  input  logic                   tx_data_get,
  input  logic                   tx_pkt_end,
  output logic                   tx_timeout
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   pending, pending_d;
  logic [3:0]           pid_q [NUM_REQ];
  logic [GW-1:0]        grant, last_grant, sel;
  logic                 any_pending;
  logic                 do_grant;
  logic                 pkt_done;
  logic                 timeout_hit;
  int                   idx;

  assign any_pending = |pending;
  assign do_grant    = (state_q == IDLE) && any_pending;
  assign pkt_done    = (state_q == ACTIVE) && (tx_pkt_end || timeout_hit);

  // Search starts just after the last owner so every requester gets a turn.
  always_comb begin
    sel = last_grant;
    idx = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (pending[idx]) sel = GW'(idx);
    end
  end

  always_comb begin
    pending_d = pending | req_pkt_start;
    if (do_grant) pending_d[sel] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_pending) state_d = ACTIVE;
      ACTIVE:  if (tx_pkt_end || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending      <= '0;
      grant        <= '0;
      last_grant   <= GW'(NUM_REQ - 1);
      tx_pkt_start <= 1'b0;
      tx_pid       <= 4'd0;
      req_pkt_end  <= '0;
      for (int i = 0; i < NUM_REQ; i++) pid_q[i] <= 4'd0;
    end else begin
      pending      <= pending_d;
      tx_pkt_start <= do_grant;
      req_pkt_end  <= '0;
      // A strobe while already pending keeps the originally captured PID.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_pkt_start[i] && !pending[i]) pid_q[i] <= req_pid[4*i +: 4];
      end
      if (do_grant) begin
        grant  <= sel;
        tx_pid <= pid_q[sel];
      end
      if (pkt_done) begin
        req_pkt_end[grant] <= 1'b1;
        last_grant         <= grant;
      end
    end
  end

`ifdef USB_TX_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        tx_timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt       <= 16'd0;
      tx_timeout_q <= 1'b0;
    end else begin
      tx_timeout_q <= timeout_hit && !tx_pkt_end;
      if (do_grant)                to_cnt <= 16'd0;
      else if (state_q == ACTIVE)  to_cnt <= to_cnt + 16'd1;
    end
  end

  // Registered abort lands exactly TIMEOUT_CYCLES after tx_pkt_start.
  assign timeout_hit = (state_q == ACTIVE) && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign tx_timeout  = tx_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign tx_timeout         = 1'b0;
`endif

  always_comb begin
    tx_data_avail = 1'b0;
    tx_data       = 8'd0;
    req_data_get  = '0;
    if (state_q == ACTIVE) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant == GW'(i)) begin
          tx_data_avail   = req_data_avail[i];
          tx_data         = req_data[8*i +: 8];
          req_data_get[i] = tx_data_get;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_busy[i] = pending[i] | ((state_q == ACTIVE) && (grant == GW'(i)));
    end
  end

endmodule
